// File: rtl/div_unit_pkg.sv
// Shared constants and state encoding for the iterative divider.
package div_unit_pkg;

    localparam int BNUM_DEFAULT = 32;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_FIX  = 2'd2,
        ST_DONE = 2'd3
    } div_state_t;

endpackage

// File: rtl/div_unit.sv
// Iterative restoring divider, one quotient bit per cycle; signed mode is
// available only when DIV_UNIT_SIGNED_EN is defined (otherwise always unsigned).
module div_unit
    import div_unit_pkg::*;
#(
    parameter int bNUM = BNUM_DEFAULT
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            start,
    input  logic            Signed,
    input  logic [bNUM-1:0] A,
    input  logic [bNUM-1:0] B,
    output logic [bNUM-1:0] Quotient,
    output logic [bNUM-1:0] Remainder,
    output logic            busy,
    output logic            done,
    output logic            DivZero
);

    localparam int CNT_W = (bNUM > 1) ? $clog2(bNUM) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(bNUM - 1);

    div_state_t      state_r;
    logic [bNUM-1:0] quo_r;
    logic [bNUM-1:0] rem_r;
    logic [bNUM-1:0] div_r;
    logic [CNT_W-1:0] cnt_r;
    logic            qneg_r;
    logic            rneg_r;
    logic            dz_r;

    logic            a_neg_s;
    logic            b_neg_s;
    logic [bNUM-1:0] a_mag_s;
    logic [bNUM-1:0] b_mag_s;
    logic [bNUM:0]   sh_s;
    logic [bNUM:0]   diff_s;

    // Operand sign extraction, magnitudes and the trial subtraction of one step.
    always_comb begin
`ifdef DIV_UNIT_SIGNED_EN
        a_neg_s = Signed & A[bNUM-1];
        b_neg_s = Signed & B[bNUM-1];
`else
        a_neg_s = Signed & 1'b0;
        b_neg_s = Signed & 1'b0;
`endif
        if (a_neg_s) begin
            a_mag_s = ~A + bNUM'(1);
        end else begin
            a_mag_s = A;
        end
        if (b_neg_s) begin
            b_mag_s = ~B + bNUM'(1);
        end else begin
            b_mag_s = B;
        end
        sh_s   = {rem_r, quo_r[bNUM-1]};
        diff_s = sh_s - {1'b0, div_r};
    end

    // Control FSM, iteration datapath and registered result outputs.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_r   <= ST_IDLE;
            quo_r     <= '0;
            rem_r     <= '0;
            div_r     <= '0;
            cnt_r     <= '0;
            qneg_r    <= 1'b0;
            rneg_r    <= 1'b0;
            dz_r      <= 1'b0;
            Quotient  <= '0;
            Remainder <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            DivZero   <= 1'b0;
        end else begin
            busy <= (state_r == ST_RUN) || (state_r == ST_FIX);
            done <= (state_r == ST_DONE);
            case (state_r)
                ST_IDLE: begin
                    cnt_r <= '0;
                    if (start) begin
                        if (B == '0) begin
                            // Zero divisor skips iteration; FIX passes the preset result through.
                            quo_r   <= '1;
                            rem_r   <= A;
                            div_r   <= '0;
                            qneg_r  <= 1'b0;
                            rneg_r  <= 1'b0;
                            dz_r    <= 1'b1;
                            state_r <= ST_FIX;
                        end else begin
                            quo_r   <= a_mag_s;
                            rem_r   <= '0;
                            div_r   <= b_mag_s;
                            qneg_r  <= a_neg_s ^ b_neg_s;
                            rneg_r  <= a_neg_s;
                            dz_r    <= 1'b0;
                            state_r <= ST_RUN;
                        end
                    end
                end
                ST_RUN: begin
                    if (diff_s[bNUM] == 1'b0) begin
                        rem_r <= diff_s[bNUM-1:0];
                        quo_r <= {quo_r[bNUM-2:0], 1'b1};
                    end else begin
                        rem_r <= sh_s[bNUM-1:0];
                        quo_r <= {quo_r[bNUM-2:0], 1'b0};
                    end
                    if (cnt_r == CNT_LAST) begin
                        cnt_r   <= '0;
                        state_r <= ST_FIX;
                    end else begin
                        cnt_r <= cnt_r + CNT_W'(1);
                    end
                end
                ST_FIX: begin
                    if (qneg_r) begin
                        quo_r <= ~quo_r + bNUM'(1);
                    end
                    if (rneg_r) begin
                        rem_r <= ~rem_r + bNUM'(1);
                    end
                    state_r <= ST_DONE;
                end
                ST_DONE: begin
                    Quotient  <= quo_r;
                    Remainder <= rem_r;
                    DivZero   <= dz_r;
                    state_r   <= ST_IDLE;
                end
                default: begin
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_div_unit.sv
// Self-checking bench for div_unit: vector table plus hand-written corner sequences.
module tb_div_unit;

    localparam int W = 32;

    logic         clock = 1'b0;
    logic         reset;
    logic         start;
    logic         Signed;
    logic [W-1:0] A;
    logic [W-1:0] B;
    logic [W-1:0] Quotient;
    logic [W-1:0] Remainder;
    logic         busy;
    logic         done;
    logic         DivZero;

    div_unit #(.bNUM(W)) dut (
        .clock     (clock),
        .reset     (reset),
        .start     (start),
        .Signed    (Signed),
        .A         (A),
        .B         (B),
        .Quotient  (Quotient),
        .Remainder (Remainder),
        .busy      (busy),
        .done      (done),
        .DivZero   (DivZero)
    );

    always #5 clock = ~clock;

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    typedef struct {
        logic [W-1:0] q;
        logic [W-1:0] r;
        logic         dz;
        int           due;
    } exp_t;

    typedef struct {
        logic         sgn;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] q;
        logic [W-1:0] r;
        logic         dz;
    } vec_t;

    exp_t sb[$];
    vec_t vecs[13];
    int   n_cmp  = 0;
    int   n_bad  = 0;
    int   n_done = 0;

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Scoreboard: each done pulse is matched against the oldest pending expectation.
    always @(negedge clock) begin : monitor
        exp_t e;
        if (done === 1'b1) begin
            n_done++;
            if (sb.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL unexpected_done: done seen at cycle %0d with nothing pending", cyc);
            end else begin
                e = sb.pop_front();
                check("quotient", Quotient, e.q);
                check("remainder", Remainder, e.r);
                check("divzero", W'(DivZero), W'(e.dz));
                check("latency_cycle", W'(cyc), W'(e.due));
            end
        end
    end

    task automatic issue(input logic sgn, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic [W-1:0] q, input logic [W-1:0] r, input logic dz,
                         input bit push);
        exp_t e;
        @(negedge clock);
        start  = 1'b1;
        Signed = sgn;
        A      = a;
        B      = b;
        if (push) begin
            e.q   = q;
            e.r   = r;
            e.dz  = dz;
            e.due = cyc + 1 + (dz ? 2 : 34);
            sb.push_back(e);
        end
        @(negedge clock);
        start  = 1'b0;
        Signed = $urandom_range(0, 1);
        A      = $urandom;
        B      = $urandom;
    endtask

    task automatic wait_idle(input string name);
        for (int i = 0; i < 100 && sb.size() != 0; i++) @(posedge clock);
        #2;
        n_cmp++;
        if (sb.size() != 0) begin
            n_bad++;
            $display("FAIL %s_timeout: %0d results still pending, required 0", name, sb.size());
            sb.delete();
        end
    endtask

    initial begin
        int d0;
        vecs[0]  = '{1'b0, 32'd100, 32'd7, 32'd14, 32'd2, 1'b0};
        vecs[1]  = '{1'b0, 32'd5, 32'd0, 32'hFFFF_FFFF, 32'd5, 1'b1};
        vecs[2]  = '{1'b0, 32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFF, 32'd0, 1'b0};
        vecs[3]  = '{1'b0, 32'd0, 32'd5, 32'd0, 32'd0, 1'b0};
        vecs[4]  = '{1'b0, 32'd3, 32'd7, 32'd0, 32'd3, 1'b0};
        vecs[5]  = '{1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd1, 32'd0, 1'b0};
        vecs[6]  = '{1'b0, 32'd123456789, 32'd1000, 32'd123456, 32'd789, 1'b0};
        vecs[7]  = '{1'b1, 32'd0, 32'd0, 32'hFFFF_FFFF, 32'd0, 1'b1};
        vecs[8]  = '{1'b0, 32'h8000_0000, 32'h10, 32'h0800_0000, 32'd0, 1'b0};
`ifdef DIV_UNIT_SIGNED_EN
        vecs[9]  = '{1'b1, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 1'b0};
        vecs[10] = '{1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'd0, 1'b0};
        vecs[11] = '{1'b1, 32'd7, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 32'd1, 1'b0};
        vecs[12] = '{1'b1, 32'hFFFF_FFF9, 32'hFFFF_FFFE, 32'd3, 32'hFFFF_FFFF, 1'b0};
`else
        vecs[9]  = '{1'b1, 32'hFFFF_FFF9, 32'd2, 32'h7FFF_FFFC, 32'd1, 1'b0};
        vecs[10] = '{1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 32'h8000_0000, 1'b0};
        vecs[11] = '{1'b1, 32'd7, 32'hFFFF_FFFE, 32'd0, 32'd7, 1'b0};
        vecs[12] = '{1'b1, 32'hFFFF_FFF9, 32'hFFFF_FFFE, 32'd0, 32'hFFFF_FFF9, 1'b0};
`endif

        reset  = 1'b1;
        start  = 1'b0;
        Signed = 1'b0;
        A      = '0;
        B      = '0;
        repeat (3) @(negedge clock);
        check("rst_quotient", Quotient, 32'd0);
        check("rst_remainder", Remainder, 32'd0);
        check("rst_busy", W'(busy), 32'd0);
        check("rst_done", W'(done), 32'd0);
        check("rst_divzero", W'(DivZero), 32'd0);

        // reset wins over a simultaneous start
        start = 1'b1;
        A     = 32'd9;
        B     = 32'd3;
        @(negedge clock);
        reset = 1'b0;
        start = 1'b0;
        repeat (2) begin
            @(negedge clock);
            check("rst_prio_busy", W'(busy), 32'd0);
        end

        // 100/7 with cycle-by-cycle busy profile
        issue(1'b0, 32'd100, 32'd7, 32'd14, 32'd2, 1'b0, 1'b1);
        for (int k = 0; k <= 34; k++) begin
            if (k != 0) @(negedge clock);
            check($sformatf("busy_k%0d", k), W'(busy), W'((k >= 1 && k <= 33) ? 1 : 0));
        end
        wait_idle("busy_seq");
        repeat (5) @(negedge clock);
        check("hold_quotient", Quotient, 32'd14);
        check("hold_remainder", Remainder, 32'd2);
        check("hold_done_low", W'(done), 32'd0);

        for (int i = 0; i < 13; i++) begin
            issue(vecs[i].sgn, vecs[i].a, vecs[i].b, vecs[i].q, vecs[i].r, vecs[i].dz, 1'b1);
            wait_idle($sformatf("vec%0d", i));
        end

        // reset during iteration aborts the operation without a done
        issue(1'b0, 32'd100, 32'd7, 32'd0, 32'd0, 1'b0, 1'b0);
        repeat (9) @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        check("abort_quotient", Quotient, 32'd0);
        check("abort_remainder", Remainder, 32'd0);
        check("abort_busy", W'(busy), 32'd0);
        check("abort_done", W'(done), 32'd0);
        check("abort_divzero", W'(DivZero), 32'd0);
        repeat (40) @(negedge clock);
        issue(1'b0, 32'd9, 32'd3, 32'd3, 32'd0, 1'b0, 1'b1);
        wait_idle("after_abort");

        // start re-asserted while busy must be ignored
        d0 = n_done;
        issue(1'b0, 32'd100, 32'd7, 32'd14, 32'd2, 1'b0, 1'b1);
        repeat (5) @(negedge clock);
        start = 1'b1;
        A     = 32'd50;
        B     = 32'd5;
        @(negedge clock);
        start = 1'b0;
        wait_idle("restart_busy");
        repeat (40) @(negedge clock);
        check("single_done_count", W'(n_done - d0), 32'd1);
        check("restart_quotient", Quotient, 32'd14);
        check("restart_remainder", Remainder, 32'd2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
